sine_phase_gen: RTL and testbench

SINE_PHASE_GEN -- requirements
Module: sine_phase_gen

---
 rtl/sine_phase_gen.sv | 117 +++++++++++
 tb/tb_sine_phase_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_gen.sv
// Phase accumulator with quarter-wave fold producing the argument for a sine stage.
// Define PHASE_DITHER_EN to add LFSR phase dither ahead of the truncation.
module sine_phase_gen #(
    parameter int unsigned G_DWIDTH   = 16,
    parameter int unsigned G_ACCWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  bypass,
    input  logic [G_ACCWIDTH-1:0] freq_word,
    input  logic                  freq_valid,
    output logic                  freq_ready,
    output logic [G_DWIDTH-1:0]   dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int unsigned FW    = G_DWIDTH + 2;
    localparam int unsigned DITHW = G_ACCWIDTH - G_DWIDTH;

    localparam logic signed [FW-1:0] HPos   = FW'(1) << (G_DWIDTH - 2);
    localparam logic signed [FW-1:0] HNeg   = -HPos;
    localparam logic signed [FW-1:0] Full   = FW'(1) << G_DWIDTH;
    localparam logic signed [FW-1:0] SatMax = (FW'(1) << (G_DWIDTH - 1)) - FW'(1);

    typedef enum logic [1:0] {SmInit, SmCompute, SmSendOutput} state_e;

    state_e                state_q;
    logic [G_ACCWIDTH-1:0] acc_q;
    logic [G_ACCWIDTH-1:0] freq_q;
    logic [G_ACCWIDTH-1:0] phase;
    logic [G_DWIDTH-1:0]   u;
    logic signed [FW-1:0]  u_ext;
    logic signed [FW-1:0]  two_u;
    logic signed [FW-1:0]  x_ext;
    logic                  out_accept;

    assign out_accept = enable && (state_q == SmSendOutput) && dout_valid && dout_ready;

`ifdef PHASE_DITHER_EN
    logic [15:0]           lfsr_q;
    logic [G_ACCWIDTH-1:0] dither;

    always_comb begin
        dither = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(DITHW)) dither[i] = lfsr_q[i];
        end
    end

    // Fibonacci LFSR, taps 16,15,13,4; advances once per accepted sample
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (out_accept) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
        end
    end

    assign phase = acc_q + dither;
`else
    assign phase = acc_q;
`endif

    // Fold the signed phase into [-1, 1) so that sin(2*pi*phase) = sin(pi/2*x)
    always_comb begin
        u     = G_DWIDTH'(phase >> DITHW);
        u_ext = {{2{u[G_DWIDTH-1]}}, u};
        two_u = u_ext <<< 1;
        x_ext = two_u;
        if (u_ext >= HPos) begin
            x_ext = Full - two_u;
            if (x_ext > SatMax) x_ext = SatMax;
        end else if (u_ext < HNeg) begin
            x_ext = -Full - two_u;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= SmInit;
            acc_q      <= '0;
            freq_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            freq_ready <= 1'b0;
        end else if (!enable) begin
            state_q    <= SmInit;
            dout_valid <= 1'b0;
            freq_ready <= 1'b0;
        end else begin
            // Accumulation below reads the old freq_q even when a load lands this cycle
            if (freq_valid && freq_ready) freq_q <= freq_word;
            case (state_q)
                SmInit: begin
                    freq_ready <= 1'b1;
                    state_q    <= SmCompute;
                end
                SmCompute: begin
                    dout       <= bypass ? u : G_DWIDTH'(x_ext);
                    dout_valid <= 1'b1;
                    state_q    <= SmSendOutput;
                end
                SmSendOutput: begin
                    if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                        acc_q      <= acc_q + freq_q;
                        state_q    <= SmCompute;
                    end
                end
                default: state_q <= SmInit;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed plus randomized bench for sine_phase_gen against a transaction-level phase model.
module tb_sine_phase_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        bypass;
    logic [31:0] freq_word;
    logic        freq_valid;
    logic        freq_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    int tests = 0;
    int fails = 0;

    // Reference: phase and step in effect, advanced once per accepted sample
    logic [31:0] acc_m;
    logic [31:0] freq_m;

    sine_phase_gen #(
        .G_DWIDTH   (16),
        .G_ACCWIDTH (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bypass     (bypass),
        .freq_word  (freq_word),
        .freq_valid (freq_valid),
        .freq_ready (freq_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expect_out(input logic [31:0] a, input bit byp);
        logic [15:0] top;
        int u;
        int x;
        top = a[31:16];
        if (byp) return top;
        u = int'($signed(top));
        if (u >= 16384) begin
            x = 65536 - 2 * u;
            if (x > 32767) x = 32767;
        end else if (u < -16384) begin
            x = -65536 - 2 * u;
        end else begin
            x = 2 * u;
        end
        return x[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        dout_ready = 1'b0;
        freq_valid = 1'b0;
        tick();
        tick();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_fready", freq_ready, 0);
        reset_n = 1'b1;
        acc_m   = 0;
        freq_m  = 0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dout_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, dout_valid, 1);
    endtask

    task automatic load_freq(input logic [31:0] w);
        int n = 0;
        while (!freq_ready && n < 20) begin
            tick();
            n++;
        end
        check("fready_wait", freq_ready, 1);
        freq_word  = w;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        freq_m     = w;
    endtask

    task automatic get_sample(input string tag);
        dout_ready = 1'b1;
        wait_valid(tag);
        check(tag, dout, expect_out(acc_m, bypass));
        tick();
        dout_ready = 1'b0;
        acc_m      = acc_m + freq_m;
        check({tag, "_clr"}, dout_valid, 0);
    endtask

    // Output handshake and frequency load on the same edge
    task automatic sample_with_load(input string tag, input logic [31:0] w);
        dout_ready = 1'b1;
        wait_valid(tag);
        check(tag, dout, expect_out(acc_m, bypass));
        check({tag, "_fready"}, freq_ready, 1);
        freq_word  = w;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        dout_ready = 1'b0;
        acc_m      = acc_m + freq_m;
        freq_m     = w;
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b1;
        bypass     = 1'b0;
        freq_word  = '0;
        freq_valid = 1'b0;
        dout_ready = 1'b0;

        // Quarter-step: 0, 7FFF, 0, 8000 repeating
        do_reset();
        load_freq(32'h4000_0000);
        for (int i = 0; i < 8; i++) get_sample("q4");

        // Eighth-step full cycle
        do_reset();
        load_freq(32'h2000_0000);
        for (int i = 0; i < 8; i++) get_sample("q8");

        // Backpressure: dout and valid hold for 10 cycles, no skipped sample
        dout_ready = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_dout", dout, expect_out(acc_m, bypass));
            check("stall_valid", dout_valid, 1);
        end
        get_sample("after_stall");
        get_sample("after_stall2");

        // Frequency change coincident with handshake uses the old step
        bypass = 1'b1;
        do_reset();
        load_freq(32'h4000_0000);
        sample_with_load("swap0", 32'h2000_0000);
        get_sample("swap1");
        get_sample("swap2");
        check("swap_model", acc_m, 32'h8000_0000);

        // Bypass: raw phase out
        do_reset();
        load_freq(32'h6000_0000);
        for (int i = 0; i < 3; i++) get_sample("byp");

        // Reset with a pending sample drops it
        bypass = 1'b0;
        get_sample("pre_rst");
        dout_ready = 1'b0;
        wait_valid("pend");
        reset_n = 1'b0;
        tick();
        check("rst_drop", dout_valid, 0);
        reset_n = 1'b1;
        acc_m   = 0;
        freq_m  = 0;
        load_freq(32'h1234_5678);
        get_sample("post_rst");
        get_sample("post_rst2");

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            bypass = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 4);
            if (r == 0) begin
                load_freq($urandom);
            end else if (r == 1) begin
                int k = $urandom_range(1, 6);
                for (int j = 0; j < k; j++) tick();
            end else if (r == 2) begin
                sample_with_load("rnd_swl", $urandom);
            end else if (r == 3) begin
                enable = 1'b0;
                tick();
                tick();
                check("dis_valid", dout_valid, 0);
                check("dis_fready", freq_ready, 0);
                enable = 1'b1;
            end
            get_sample("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
